enemy_life_ctrl: RTL
====================

Name: enemy_life_ctrl

Overview:
- Downstream of the enemy hit/boom judge. Consumes its `boom` flag and owns the enemy's lifecycle: alive/descending, explosion animation, respawn delay, respawn.
- Drives enemy position, `enemy_en` and reload health back to the judge and renderer.
- Runs on the game clock and steps on a one-cycle `frame_tick` strobe.

Parameters:
- MAX_HEALTH, 3: health loaded at each spawn (1..7).
- EXPL_FRAMES, 4: number of explosion animation frames (2..8).
- FRAME_TICKS, 6: frame_ticks per animation frame (1..63).
- RESPAWN_TICKS, 60: frame_ticks spent in WAIT before respawn (1..255).
- Y_STEP, 1: pixels descended per frame_tick while alive.
- Y_BOTTOM, 480: ep_y value at which the enemy escapes.

Ports:
- clk  in  1  game clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-clk strobe per video frame, clk domain
- game_en  in  1  1 = game running
- boom  in  1  level from the boom judge, on another clock; synchronised internally
- spawn_x  in  10  x position sampled at spawn
- enemy_en  out  1  1 = enemy alive and hittable
- enemy_health  out  3  health to load into the judge
- ep_x  out  10  enemy x
- ep_y  out  10  enemy y
- expl_active  out  1  explosion animation running
- expl_frame  out  3  current animation frame index, 0..EXPL_FRAMES-1
- kill_pulse  out  1  one-clk pulse on each kill
- escape_pulse  out  1  one-clk pulse when the enemy reaches Y_BOTTOM

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except enemy_health=MAX_HEALTH; sync flops 0; counters 0.
- boom path: 2-flop synchroniser, then a rising-edge detect against a third flop. A boom rise is acted on at the 3rd clk edge after it is stable. Only rising edges are used: a boom held high causes no repeat kill.
- States: IDLE, ALIVE, EXPLODE, WAIT.
- IDLE:
  - Outputs held at reset values.
  - On game_en=1: spawn and go to ALIVE next clk.
- Spawn, taking effect on entry to ALIVE:
  - ep_x <= spawn_x, ep_y <= 0.
  - enemy_health <= MAX_HEALTH, enemy_en <= 1.
- ALIVE:
  - Each frame_tick: ep_y <= ep_y + Y_STEP.
  - If the sum is >= Y_BOTTOM: escape_pulse for 1 clk, enemy_en <= 0, go to WAIT; ep_y is clamped to Y_BOTTOM.
  - On a boom edge: kill_pulse for 1 clk, enemy_en <= 0, expl_active <= 1, expl_frame <= 0, tick counter cleared, go to EXPLODE.
  - ep_x/ep_y freeze at their last values.
- EXPLODE:
  - Count frame_ticks. Each time the count reaches FRAME_TICKS, clear the count and advance expl_frame.
  - After frame EXPL_FRAMES-1 completes: expl_active <= 0, expl_frame <= 0, go to WAIT.
  - Further boom edges are ignored.
- WAIT:
  - Count frame_ticks up to RESPAWN_TICKS, then spawn and go to ALIVE.
  - enemy_health stays at MAX_HEALTH throughout WAIT, so the judge can reload it.
- Simultaneous events:
  - A boom edge and an escape in the same clk: boom wins (kill, no escape_pulse).
  - A boom edge and frame_tick in the same clk: no movement that cycle.
- game_en=0 in any state: next clk goes to IDLE with outputs at reset values, no pulses. The boom edge detector keeps running, so a stale boom level cannot fire later.
- Counter widths:
  - tick counter: 6 bits for animation, 8 bits for WAIT; may be shared at 8 bits.
  - ep_y arithmetic in 11 bits before the compare, so there is no wrap at 1023.
- Pulses are registered outputs and are never asserted in IDLE.

Optional Feature:
- Macro: ENEMY_SCORE_EN.
- When defined:
  - Adds output `score` [11:0], reset 0.
  - +1 per kill_pulse, saturating at 4095.
  - Cleared on entry to IDLE from any other state.
- When undefined: no `score` port and no score logic.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ALIVE/EXPLODE/WAIT),
  - coordinate width 10 and screen constants 640/480,
  - health width 3.
- One sub-module: `edge_sync`, a 2-flop synchroniser plus rising-edge pulse. It is reused for other cross-clock flags.

Test Plan:
- Reset then game_en=1 with spawn_x=200 -> 1 clk later ALIVE, enemy_en=1, ep_x=200, ep_y=0, enemy_health=3.
- 10 frame_ticks in ALIVE with Y_STEP=1 -> ep_y=10. Then boom high -> kill_pulse exactly once at the 3rd clk; enemy_en=0; expl_active=1; ep_y stays 10.
- In EXPLODE, 24 frame_ticks -> expl_frame steps 0,1,2,3 every 6 ticks, then expl_active=0. A second boom pulse during EXPLODE gives no kill_pulse.
- In WAIT, 60 frame_ticks -> respawn with ep_y=0, enemy_en=1, health=3. boom held high across the respawn gives no new kill until boom falls and rises again.
- Alive until ep_y=479, then boom edge and frame_tick in the same clk -> kill_pulse=1, escape_pulse=0, ep_y=479.
- game_en dropped mid-EXPLODE -> next clk IDLE, all outputs 0. Async rst low mid-ALIVE -> outputs clear immediately, without waiting for clk. With ENEMY_SCORE_EN: 3 kills -> score=3; score clears on IDLE.

Source files
------------

// File: rtl/enemy_life_ctrl_pkg.sv
// Shared types and constants for the enemy lifecycle controller and its helpers.
package enemy_life_ctrl_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int HEALTH_W = 3;
  localparam int TICK_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIVE   = 2'd1,
    ST_EXPLODE = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  // One extra bit so a step past the bottom of the screen never wraps at 1023.
  function automatic logic [COORD_W:0] y_advance(input logic [COORD_W-1:0] y,
                                                 input logic [COORD_W-1:0] step);
    return {1'b0, y} + {1'b0, step};
  endfunction

endpackage

// File: rtl/enemy_life_ctrl_edge_sync.sv
// edge_sync: two-flop synchroniser for an asynchronous level plus a rising-edge
// pulse taken against a third flop; reusable for any cross-clock flag.
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  // Shift register: [0],[1] synchronise, [2] holds the previous synchronised level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/enemy_life_ctrl.sv
// Enemy lifecycle: spawn, descend, explode on boom, respawn after a delay.
// Optional score counter enabled by defining ENEMY_SCORE_EN.
module enemy_life_ctrl
  import enemy_life_ctrl_pkg::*;
#(
  parameter int MAX_HEALTH    = 3,
  parameter int EXPL_FRAMES   = 4,
  parameter int FRAME_TICKS   = 6,
  parameter int RESPAWN_TICKS = 60,
  parameter int Y_STEP        = 1,
  parameter int Y_BOTTOM      = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                game_en,
  input  logic                boom,
  input  logic [COORD_W-1:0]  spawn_x,
  output logic                enemy_en,
  output logic [HEALTH_W-1:0] enemy_health,
  output logic [COORD_W-1:0]  ep_x,
  output logic [COORD_W-1:0]  ep_y,
  output logic                expl_active,
  output logic [2:0]          expl_frame,
  output logic                kill_pulse,
  output logic                escape_pulse
`ifdef ENEMY_SCORE_EN
  ,output logic [11:0]        score
`endif
);

  state_e              state_q;
  logic                en_q;
  logic [HEALTH_W-1:0] health_q;
  logic [COORD_W-1:0]  x_q;
  logic [COORD_W-1:0]  y_q;
  logic                act_q;
  logic [2:0]          frame_q;
  logic [TICK_W-1:0]   tick_q;
  logic                kill_q;
  logic                esc_q;
  logic                boom_rise_s;
  logic [COORD_W:0]    y_sum_d;
  logic                kill_fire_s;

  edge_sync u_boom_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (boom),
    .rise_o (boom_rise_s)
  );

  assign y_sum_d     = y_advance(y_q, COORD_W'(Y_STEP));
  assign kill_fire_s = game_en & (state_q == ST_ALIVE) & boom_rise_s;

  // Lifecycle FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      health_q <= HEALTH_W'(MAX_HEALTH);
      x_q      <= '0;
      y_q      <= '0;
      act_q    <= 1'b0;
      frame_q  <= 3'd0;
      tick_q   <= '0;
      kill_q   <= 1'b0;
      esc_q    <= 1'b0;
    end else begin
      kill_q   <= 1'b0;
      esc_q    <= 1'b0;
      health_q <= HEALTH_W'(MAX_HEALTH);
      if (!game_en) begin
        state_q <= ST_IDLE;
        en_q    <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
        act_q   <= 1'b0;
        frame_q <= 3'd0;
        tick_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ALIVE;
            en_q    <= 1'b1;
            x_q     <= spawn_x;
            y_q     <= '0;
            tick_q  <= '0;
          end
          ST_ALIVE: begin
            // A kill outranks both movement and escape in the same cycle.
            if (boom_rise_s) begin
              state_q <= ST_EXPLODE;
              kill_q  <= 1'b1;
              en_q    <= 1'b0;
              act_q   <= 1'b1;
              frame_q <= 3'd0;
              tick_q  <= '0;
            end else if (frame_tick) begin
              if (y_sum_d >= (COORD_W+1)'(Y_BOTTOM)) begin
                state_q <= ST_WAIT;
                esc_q   <= 1'b1;
                en_q    <= 1'b0;
                y_q     <= COORD_W'(Y_BOTTOM);
                tick_q  <= '0;
              end else begin
                y_q <= y_sum_d[COORD_W-1:0];
              end
            end
          end
          ST_EXPLODE: begin
            if (frame_tick) begin
              if (tick_q + 8'd1 == TICK_W'(FRAME_TICKS)) begin
                tick_q <= '0;
                if (frame_q == 3'(EXPL_FRAMES - 1)) begin
                  state_q <= ST_WAIT;
                  act_q   <= 1'b0;
                  frame_q <= 3'd0;
                end else begin
                  frame_q <= frame_q + 3'd1;
                end
              end else begin
                tick_q <= tick_q + 8'd1;
              end
            end
          end
          ST_WAIT: begin
            if (frame_tick) begin
              if (tick_q + 8'd1 == TICK_W'(RESPAWN_TICKS)) begin
                state_q <= ST_ALIVE;
                en_q    <= 1'b1;
                x_q     <= spawn_x;
                y_q     <= '0;
                tick_q  <= '0;
              end else begin
                tick_q <= tick_q + 8'd1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ENEMY_SCORE_EN
  logic [11:0] score_q;

  // Kill counter, saturating, wiped whenever the game stops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= 12'd0;
    end else if (!game_en) begin
      score_q <= 12'd0;
    end else if (kill_fire_s && (score_q != 12'hFFF)) begin
      score_q <= score_q + 12'd1;
    end
  end

  assign score = score_q;
`endif

  assign enemy_en     = en_q;
  assign enemy_health = health_q;
  assign ep_x         = x_q;
  assign ep_y         = y_q;
  assign expl_active  = act_q;
  assign expl_frame   = frame_q;
  assign kill_pulse   = kill_q;
  assign escape_pulse = esc_q;

endmodule
